// File: rtl/regfile_sequencer.sv
// Command-driven select/strobe sequencer for the 8085 register-pair file.
// Optional FETCH opcode (op 12, PC forced) is enabled by defining REGSEQ_FETCH_EN.
module regfile_sequencer #(
  parameter int unsigned STROBE_W = 2,
  parameter int unsigned PAIR_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [PAIR_W-1:0] cmd_pair,
  input  logic [15:0]       wr_data,
  output logic              bc_rw,
  output logic              de_rw,
  output logic              hl_rw,
  output logic              wz_rw,
  output logic              pc_rw,
  output logic              sp_rw,
  output logic              rreg_rd,
  output logic              lreg_rd,
  output logic              rreg_wr,
  output logic              lreg_wr,
  output logic              dreg_rd,
  output logic              dreg_wr,
  output logic              dreg_inc,
  output logic              dreg_dec,
  output logic              dreg_cnt,
  output logic              dreg_cnt2,
  output logic [7:0]        data_out,
  output logic              data_oe,
  input  logic [7:0]        data_in,
  input  logic              carry_in,
  output logic              done,
  output logic              err,
  output logic [15:0]       rd_data,
  output logic              cy_out
);

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StDone} state_e;

  localparam logic [3:0] OpNop  = 4'd0;
  localparam logic [3:0] OpRdl  = 4'd1;
  localparam logic [3:0] OpRdh  = 4'd2;
  localparam logic [3:0] OpRdw  = 4'd3;
  localparam logic [3:0] OpWrl  = 4'd4;
  localparam logic [3:0] OpWrh  = 4'd5;
  localparam logic [3:0] OpWrw  = 4'd6;
  localparam logic [3:0] OpAddr = 4'd7;
  localparam logic [3:0] OpInc1 = 4'd8;
  localparam logic [3:0] OpInc2 = 4'd9;
  localparam logic [3:0] OpDec1 = 4'd10;
  localparam logic [3:0] OpDec2 = 4'd11;
  localparam logic [3:0] OpFetch = 4'd12;

  localparam logic [1:0] CntLast = 2'(STROBE_W - 1);

  // Strobe vector order: {dreg_wr, dreg_rd, lreg_wr, rreg_wr, lreg_rd, rreg_rd}
  function automatic logic [5:0] phase_strobe(input logic [3:0] op, input logic ph);
    logic [5:0] s;
    s = 6'b000000;
    case (op)
      OpRdl:  s = 6'b000001;
      OpRdh:  s = 6'b000010;
      OpRdw:  s = ph ? 6'b000010 : 6'b000001;
      OpWrl:  s = 6'b000100;
      OpWrh:  s = 6'b001000;
      OpWrw:  s = ph ? 6'b001000 : 6'b000100;
      OpAddr: s = 6'b010000;
      OpInc1, OpInc2, OpDec1, OpDec2: s = ph ? 6'b100000 : 6'b010000;
`ifdef REGSEQ_FETCH_EN
      OpFetch: s = ph ? 6'b100000 : 6'b010000;
`endif
      default: s = 6'b000000;
    endcase
    return s;
  endfunction

  function automatic logic op_legal(input logic [3:0] op);
`ifdef REGSEQ_FETCH_EN
    return op <= OpFetch;
`else
    return op <= OpDec2;
`endif
  endfunction

  function automatic logic two_phase(input logic [3:0] op);
    logic tp;
    tp = op inside {OpRdw, OpWrw, OpInc1, OpInc2, OpDec1, OpDec2};
`ifdef REGSEQ_FETCH_EN
    tp = tp || (op == OpFetch);
`endif
    return tp;
  endfunction

  state_e            state_q, state_d;
  logic              phase_q, phase_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;
  logic [PAIR_W-1:0] pair_q, pair_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              ill_q, ill_d;
  logic [15:0]       rd_data_q, rd_data_d;
  logic              cy_q, cy_d;
  logic [5:0]        sel_q, sel_d;
  logic [5:0]        strb_q, strb_d;
  logic [3:0]        ctrl_q, ctrl_d;
  logic [7:0]        dout_q, dout_d;
  logic              oe_q, oe_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;

  logic [5:0] strb_now;
  logic       active, is_wr, is_inc, is_dec, is_cnt1;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    pair_d    = pair_q;
    wdata_d   = wdata_q;
    ill_d     = ill_q;
    rd_data_d = rd_data_q;
    cy_d      = cy_q;
    strb_now  = phase_strobe(op_q, phase_q);

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          pair_d  = cmd_pair;
          wdata_d = wr_data;
          phase_d = 1'b0;
          cnt_d   = 2'd0;
`ifdef REGSEQ_FETCH_EN
          if (cmd_op == OpFetch) pair_d = PAIR_W'(4);
`endif
          ill_d   = !op_legal(cmd_op) || (pair_d >= PAIR_W'(6));
          state_d = (ill_d || cmd_op == OpNop) ? StDone : StSetup;
        end
      end
      StSetup: begin
        state_d = StStrobe;
        cnt_d   = 2'd0;
      end
      StStrobe: begin
        if (cnt_q == CntLast) begin
          state_d = StHold;
          // Sample on the last strobe cycle so the register file has settled.
          if (strb_now[0]) rd_data_d[7:0]  = data_in;
          if (strb_now[1]) rd_data_d[15:8] = data_in;
          if (strb_now[5]) cy_d = carry_in;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StHold: begin
        if (two_phase(op_q) && !phase_q) begin
          state_d = StStrobe;
          phase_d = 1'b1;
          cnt_d   = 2'd0;
        end else begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so they leave the flops glitch-free.
    active  = state_d inside {StSetup, StStrobe, StHold};
    is_wr   = op_d inside {OpWrl, OpWrh, OpWrw};
    is_inc  = op_d inside {OpInc1, OpInc2};
    is_dec  = op_d inside {OpDec1, OpDec2};
    is_cnt1 = op_d inside {OpInc1, OpDec1};
`ifdef REGSEQ_FETCH_EN
    is_inc  = is_inc || (op_d == OpFetch);
    is_cnt1 = is_cnt1 || (op_d == OpFetch);
`endif
    sel_d = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      sel_d[i] = active && (pair_d == PAIR_W'(i));
    end
    strb_d  = (state_d == StStrobe) ? phase_strobe(op_d, phase_d) : 6'b000000;
    ctrl_d  = active ? {is_inc, is_dec, is_cnt1, is_inc || is_dec ? !is_cnt1 : 1'b0}
                     : 4'b0000;
    oe_d    = active && is_wr;
    dout_d  = 8'h00;
    if (oe_d) begin
      dout_d = (op_d == OpWrh || (op_d == OpWrw && phase_d)) ? wdata_d[15:8] : wdata_d[7:0];
    end
    done_d  = state_d == StDone;
    err_d   = done_d && ill_d;
    ready_d = state_d == StIdle;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      phase_q   <= 1'b0;
      cnt_q     <= 2'd0;
      op_q      <= 4'd0;
      pair_q    <= '0;
      wdata_q   <= 16'h0000;
      ill_q     <= 1'b0;
      rd_data_q <= 16'h0000;
      cy_q      <= 1'b0;
      sel_q     <= 6'b000000;
      strb_q    <= 6'b000000;
      ctrl_q    <= 4'b0000;
      dout_q    <= 8'h00;
      oe_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      pair_q    <= pair_d;
      wdata_q   <= wdata_d;
      ill_q     <= ill_d;
      rd_data_q <= rd_data_d;
      cy_q      <= cy_d;
      sel_q     <= sel_d;
      strb_q    <= strb_d;
      ctrl_q    <= ctrl_d;
      dout_q    <= dout_d;
      oe_q      <= oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
    end
  end

  assign cmd_ready = ready_q;
  assign {sp_rw, pc_rw, wz_rw, hl_rw, de_rw, bc_rw} = sel_q;
  assign {dreg_wr, dreg_rd, lreg_wr, rreg_wr, lreg_rd, rreg_rd} = strb_q;
  assign {dreg_inc, dreg_dec, dreg_cnt, dreg_cnt2} = ctrl_q;
  assign data_out = dout_q;
  assign data_oe  = oe_q;
  assign done     = done_q;
  assign err      = err_q;
  assign rd_data  = rd_data_q;
  assign cy_out   = cy_q;

endmodule
